// File: rtl/alu_instr_decoder_pkg.sv
// Shared opcode, prefix and ALU control encodings for the GSU opcode decoder.
// Imported by the decoder top and its prefix-state register block.
package alu_instr_decoder_pkg;

  localparam logic [7:0] OP_ALT1 = 8'h3D;
  localparam logic [7:0] OP_ALT2 = 8'h3E;
  localparam logic [7:0] OP_ALT3 = 8'h3F;
  localparam logic [7:0] OP_ROR  = 8'h97;
  localparam logic [7:0] OP_SWAP = 8'h4D;

  localparam logic [3:0] HI_TO   = 4'h1;
  localparam logic [3:0] HI_WITH = 4'h2;
  localparam logic [3:0] HI_ALT  = 4'h3;
  localparam logic [3:0] HI_SWAP = 4'h4;
  localparam logic [3:0] HI_ADD  = 4'h5;
  localparam logic [3:0] HI_SUB  = 4'h6;
  localparam logic [3:0] HI_AND  = 4'h7;
  localparam logic [3:0] HI_ROR  = 4'h9;
  localparam logic [3:0] HI_FROM = 4'hB;
  localparam logic [3:0] HI_OR   = 4'hC;

  localparam logic Y_SRC_BUS = 1'b0;
  localparam logic Y_SRC_IMM = 1'b1;

  typedef enum logic [2:0] {
    Z_ADDSUB = 3'b000,
    Z_AND    = 3'b001,
    Z_OR     = 3'b010,
    Z_XOR    = 3'b011,
    Z_ROR    = 3'b100,
    Z_SWAP   = 3'b101
  } z_src_e;

  // {alt2, alt1}
  typedef enum logic [1:0] {
    ALT0 = 2'b00,
    ALT1 = 2'b01,
    ALT2 = 2'b10,
    ALT3 = 2'b11
  } alt_mode_e;

  typedef struct packed {
    logic       y_src;
    z_src_e     z_src;
    logic       add_sub;
    logic [7:0] alu_instr;
    logic [3:0] sreg;
    logic [3:0] yreg;
    logic [3:0] dreg;
    logic       reg_we;
    logic       flags_we;
  } alu_ctrl_t;

  function automatic alu_ctrl_t set_operand(input alu_ctrl_t c, input logic imm, input logic [3:0] n);
    alu_ctrl_t r;
    r       = c;
    r.yreg  = n;
    r.y_src = imm ? Y_SRC_IMM : Y_SRC_BUS;
    r.alu_instr = imm ? {4'h0, n} : 8'h00;
    return r;
  endfunction

endpackage

// File: rtl/alu_instr_decoder_prefix_state.sv
// Prefix state held across opcodes: ALT1/ALT2 flags, WITH (b) flag and source/destination registers.
// Execution of any non-prefix opcode returns everything to the defaults.
module alu_prefix_state
  import alu_instr_decoder_pkg::*;
#(
  parameter logic [3:0] DEFAULT_REG = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alt_we_i,
  input  logic       alt1_i,
  input  logic       alt2_i,
  input  logic       with_we_i,
  input  logic       to_we_i,
  input  logic       from_we_i,
  input  logic [3:0] reg_n_i,
  input  logic       clear_i,
  output logic       alt1_o,
  output logic       alt2_o,
  output logic       b_o,
  output logic [3:0] sreg_o,
  output logic [3:0] dreg_o
);

  logic       alt1_q, alt2_q, b_q;
  logic [3:0] sreg_q, dreg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alt1_q <= 1'b0;
      alt2_q <= 1'b0;
      b_q    <= 1'b0;
      sreg_q <= DEFAULT_REG;
      dreg_q <= DEFAULT_REG;
    end else if (clear_i) begin
      alt1_q <= 1'b0;
      alt2_q <= 1'b0;
      b_q    <= 1'b0;
      sreg_q <= DEFAULT_REG;
      dreg_q <= DEFAULT_REG;
    end else begin
      if (alt_we_i) begin
        alt1_q <= alt1_i;
        alt2_q <= alt2_i;
      end
      if (with_we_i) begin
        b_q    <= 1'b1;
        sreg_q <= reg_n_i;
        dreg_q <= reg_n_i;
      end
      if (to_we_i)   dreg_q <= reg_n_i;
      if (from_we_i) sreg_q <= reg_n_i;
    end
  end

  assign alt1_o = alt1_q;
  assign alt2_o = alt2_q;
  assign b_o    = b_q;
  assign sreg_o = sreg_q;
  assign dreg_o = dreg_q;

endmodule

// File: rtl/alu_instr_decoder.sv
// GSU opcode decoder: turns the opcode stream plus prefix state into one registered set of
// ALU and register-file controls per executed opcode.
module alu_instr_decoder
  import alu_instr_decoder_pkg::*;
#(
  parameter logic [3:0] DEFAULT_REG = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  input  logic       stall,
  output logic       instr_ready,
  output logic       op_valid,
  output logic       y_src_sel,
  output logic [2:0] z_src_sel,
  output logic       add_sub_sel,
  output logic [7:0] alu_instr,
  output logic [3:0] sreg_sel,
  output logic [3:0] yreg_sel,
  output logic [3:0] dreg_sel,
  output logic       reg_we,
  output logic       flags_we,
  output logic       alt1,
  output logic       alt2,
  output logic       b_flag,
  output logic       illegal
);

  logic       accept;
  logic       pf_alt1, pf_alt2, pf_b;
  logic [3:0] pf_sreg, pf_dreg;
  logic       alt_we, alt1_n, alt2_n, with_we, to_we, from_we;
  logic       is_prefix, legal, exec;
  logic [3:0] n;
  alt_mode_e  alt_mode;
  alu_ctrl_t  ctrl_d, ctrl_q;
  logic       op_valid_q, illegal_q;

  assign instr_ready = ~stall;
  assign accept      = instr_valid & ~stall;
  assign n           = instr[3:0];
  assign alt_mode    = alt_mode_e'({pf_alt2, pf_alt1});
  assign exec        = accept & ~is_prefix;

  alu_prefix_state #(.DEFAULT_REG(DEFAULT_REG)) u_prefix (
    .clk       (clk),
    .rst_n     (rst_n),
    .alt_we_i  (accept & alt_we),
    .alt1_i    (alt1_n),
    .alt2_i    (alt2_n),
    .with_we_i (accept & with_we),
    .to_we_i   (accept & to_we),
    .from_we_i (accept & from_we),
    .reg_n_i   (n),
    .clear_i   (exec),
    .alt1_o    (pf_alt1),
    .alt2_o    (pf_alt2),
    .b_o       (pf_b),
    .sreg_o    (pf_sreg),
    .dreg_o    (pf_dreg)
  );

  always_comb begin
    is_prefix = 1'b0;
    legal     = 1'b0;
    alt_we    = 1'b0;
    alt1_n    = 1'b0;
    alt2_n    = 1'b0;
    with_we   = 1'b0;
    to_we     = 1'b0;
    from_we   = 1'b0;
    ctrl_d          = '0;
    ctrl_d.sreg     = pf_sreg;
    ctrl_d.dreg     = pf_dreg;
    ctrl_d.reg_we   = 1'b1;
    ctrl_d.flags_we = 1'b1;
    unique case (instr[7:4])
      HI_ALT: begin
        if (instr == OP_ALT1 || instr == OP_ALT2 || instr == OP_ALT3) begin
          is_prefix = 1'b1;
          alt_we    = 1'b1;
          alt1_n    = (instr != OP_ALT2);
          alt2_n    = (instr != OP_ALT1);
        end
      end
      HI_WITH: begin
        is_prefix = 1'b1;
        with_we   = 1'b1;
      end
      HI_TO: begin
        if (pf_b) begin
          // MOVE: copy old source into Rn through ADD #0, flags untouched
          legal           = 1'b1;
          ctrl_d          = set_operand(ctrl_d, 1'b1, 4'h0);
          ctrl_d.dreg     = n;
          ctrl_d.flags_we = 1'b0;
        end else begin
          is_prefix = 1'b1;
          to_we     = 1'b1;
        end
      end
      HI_FROM: begin
        if (pf_b) begin
          legal       = 1'b1;
          ctrl_d      = set_operand(ctrl_d, 1'b1, 4'h0);
          ctrl_d.sreg = n;
        end else begin
          is_prefix = 1'b1;
          from_we   = 1'b1;
        end
      end
      HI_ADD: begin
        legal  = (alt_mode == ALT0) || (alt_mode == ALT2);
        ctrl_d = set_operand(ctrl_d, alt_mode == ALT2, n);
      end
      HI_SUB: begin
        legal          = (alt_mode != ALT1);
        ctrl_d         = set_operand(ctrl_d, alt_mode == ALT2, n);
        ctrl_d.add_sub = 1'b1;
        ctrl_d.reg_we  = (alt_mode != ALT3);
      end
      HI_AND: begin
        legal        = (n != 4'h0) && ((alt_mode == ALT0) || (alt_mode == ALT2));
        ctrl_d       = set_operand(ctrl_d, alt_mode == ALT2, n);
        ctrl_d.z_src = Z_AND;
      end
      HI_OR: begin
        legal        = (n != 4'h0);
        ctrl_d       = set_operand(ctrl_d, pf_alt2, n);
        ctrl_d.z_src = pf_alt1 ? Z_XOR : Z_OR;
      end
      HI_ROR: begin
        legal        = (instr == OP_ROR);
        ctrl_d.z_src = Z_ROR;
      end
      HI_SWAP: begin
        legal        = (instr == OP_SWAP);
        ctrl_d.z_src = Z_SWAP;
      end
      default: legal = 1'b0;
    endcase
    if (!is_prefix && !legal) begin
      ctrl_d.reg_we   = 1'b0;
      ctrl_d.flags_we = 1'b0;
    end
  end

  // Controls only change on an executed opcode; prefixes and idle cycles leave them held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      op_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      op_valid_q <= exec;
      illegal_q  <= exec & ~legal;
      if (exec) ctrl_q <= ctrl_d;
    end
  end

  assign op_valid    = op_valid_q;
  assign illegal     = illegal_q;
  assign y_src_sel   = ctrl_q.y_src;
  assign z_src_sel   = ctrl_q.z_src;
  assign add_sub_sel = ctrl_q.add_sub;
  assign alu_instr   = ctrl_q.alu_instr;
  assign sreg_sel    = ctrl_q.sreg;
  assign yreg_sel    = ctrl_q.yreg;
  assign dreg_sel    = ctrl_q.dreg;
  assign reg_we      = ctrl_q.reg_we;
  assign flags_we    = ctrl_q.flags_we;
  assign alt1        = pf_alt1;
  assign alt2        = pf_alt2;
  assign b_flag      = pf_b;

endmodule

// File: tb/tb_alu_instr_decoder.sv
// Scoreboard bench for alu_instr_decoder: stimulus pushes hand-computed controls, a negedge
// monitor pops and compares whenever op_valid is presented.
module tb_alu_instr_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       stall;
  logic       instr_ready, op_valid, y_src_sel, add_sub_sel, reg_we, flags_we;
  logic       alt1, alt2, b_flag, illegal;
  logic [2:0] z_src_sel;
  logic [7:0] alu_instr;
  logic [3:0] sreg_sel, yreg_sel, dreg_sel;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    int ill, ysrc, z, addsub, imm, sreg, yreg, dreg, we, fwe;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  alu_instr_decoder dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .instr_ready(instr_ready), .op_valid(op_valid), .y_src_sel(y_src_sel), .z_src_sel(z_src_sel),
    .add_sub_sel(add_sub_sel), .alu_instr(alu_instr), .sreg_sel(sreg_sel), .yreg_sel(yreg_sel),
    .dreg_sel(dreg_sel), .reg_we(reg_we), .flags_we(flags_we), .alt1(alt1), .alt2(alt2),
    .b_flag(b_flag), .illegal(illegal)
  );

  // A negative expected value means the field is not checked for that op.
  task automatic chk(input string nm, input int act, input int expv);
    if (expv < 0) return;
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  function automatic exp_t mk(input string nm, input int ill, input int ysrc, input int z,
                              input int addsub, input int imm, input int sreg, input int yreg,
                              input int dreg, input int we, input int fwe);
    exp_t e;
    e.name = nm; e.ill = ill; e.ysrc = ysrc; e.z = z; e.addsub = addsub; e.imm = imm;
    e.sreg = sreg; e.yreg = yreg; e.dreg = dreg; e.we = we; e.fwe = fwe;
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (illegal && !op_valid) chk("illegal_without_op_valid", 1, 0);
      if (op_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_op_valid", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk({e.name, ".illegal"},  int'(illegal),     e.ill);
          chk({e.name, ".y_src"},    int'(y_src_sel),   e.ysrc);
          chk({e.name, ".z_src"},    int'(z_src_sel),   e.z);
          chk({e.name, ".add_sub"},  int'(add_sub_sel), e.addsub);
          chk({e.name, ".alu_instr"},int'(alu_instr),   e.imm);
          chk({e.name, ".sreg"},     int'(sreg_sel),    e.sreg);
          chk({e.name, ".yreg"},     int'(yreg_sel),    e.yreg);
          chk({e.name, ".dreg"},     int'(dreg_sel),    e.dreg);
          chk({e.name, ".reg_we"},   int'(reg_we),      e.we);
          chk({e.name, ".flags_we"}, int'(flags_we),    e.fwe);
          $display("txn %s: z=%0d ysrc=%0d imm=%02h s=%0d y=%0d d=%0d we=%0d fwe=%0d ill=%0d",
                   e.name, z_src_sel, y_src_sel, alu_instr, sreg_sel, yreg_sel, dreg_sel,
                   reg_we, flags_we, illegal);
        end
      end
    end
  end

  // Drive one opcode for one cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [7:0] op);
    instr       = op;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; instr = 8'h00; instr_valid = 1'b0; stall = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("reset.op_valid", int'(op_valid), 0);
    chk("reset.alt1", int'(alt1), 0);
    chk("reset.alt2", int'(alt2), 0);
    chk("reset.b_flag", int'(b_flag), 0);
    chk("reset.reg_we", int'(reg_we), 0);
    chk("reset.dreg", int'(dreg_sel), 0);
    chk("reset.ready", int'(instr_ready), 1);

    // name ill ysrc z as imm sreg yreg dreg we fwe
    exp_q.push_back(mk("ADD_R4", 0, 0, 0, 0, 0, 0, 4, 0, 1, 1));
    issue(8'h54);

    issue(8'h3E);
    chk("alt2_after_3E", int'(alt2), 1);
    exp_q.push_back(mk("SUB_imm3", 0, 1, 0, 1, 3, 0, -1, 0, 1, 1));
    issue(8'h63);
    exp_q.push_back(mk("SUB_R3", 0, 0, 0, 1, 0, 0, 3, 0, 1, 1));
    issue(8'h63);

    issue(8'h3F);
    exp_q.push_back(mk("XOR_imm5", 0, 1, 3, -1, 5, 0, -1, 0, 1, 1));
    issue(8'hC5);
    issue(8'h3D);
    exp_q.push_back(mk("XOR_R5", 0, 0, 3, -1, 0, 0, 5, 0, 1, 1));
    issue(8'hC5);

    issue(8'h25);
    chk("b_after_WITH", int'(b_flag), 1);
    exp_q.push_back(mk("MOVE_R7_R5", 0, 1, 0, 0, 0, 5, -1, 7, 1, 0));
    issue(8'h17);
    chk("b_after_MOVE", int'(b_flag), 0);

    issue(8'h25);
    exp_q.push_back(mk("MOVES_R5_R9", 0, 1, 0, 0, 0, 9, -1, 5, 1, 1));
    issue(8'hB9);

    issue(8'h13);
    issue(8'hB2);
    issue(8'h3F);
    exp_q.push_back(mk("CMP_R1", 0, 0, 0, 1, 0, 2, 1, 3, 0, 1));
    issue(8'h61);
    exp_q.push_back(mk("ROR", 0, 0, 4, -1, -1, 0, -1, 0, 1, 1));
    issue(8'h97);
    exp_q.push_back(mk("AND_R0_illegal", 1, -1, -1, -1, -1, -1, -1, -1, 0, 0));
    issue(8'h70);
    issue(8'h3D);
    exp_q.push_back(mk("SBC_illegal", 1, -1, -1, -1, -1, -1, -1, -1, 0, 0));
    issue(8'h63);
    exp_q.push_back(mk("SWAP", 0, 0, 5, -1, -1, 0, -1, 0, 1, 1));
    issue(8'h4D);

    // Prefix, then a stalled opcode: nothing may move for three cycles.
    issue(8'h3D);
    stall = 1'b1; instr = 8'h54; instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall.ready", int'(instr_ready), 0);
      chk("stall.op_valid", int'(op_valid), 0);
      chk("stall.alt1", int'(alt1), 1);
      chk("stall.z_held", int'(z_src_sel), 5);
      chk("stall.reg_we_held", int'(reg_we), 1);
    end
    stall = 1'b0;
    exp_q.push_back(mk("ADC_illegal", 1, -1, -1, -1, -1, -1, -1, -1, 0, 0));
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("adc.alt1_cleared", int'(alt1), 0);

    // Reset mid-sequence discards the pending ALT1.
    issue(8'h3D);
    chk("alt1_before_reset", int'(alt1), 1);
    rst_n = 1'b0;
    #2;
    chk("reset_async.alt1", int'(alt1), 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    exp_q.push_back(mk("ADD_R4_after_reset", 0, 0, 0, 0, 0, 0, 4, 0, 1, 1));
    issue(8'h54);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) idle(1);
    chk("scoreboard_drained", exp_q.size(), 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
